// File: rtl/ex_mem_stage_reg_pkg.sv
// Shared definitions for the EX->MEM stage register.
// - Control-bit positions inside the control bundle.
// - Bit offsets of the fields packed into the data payload.
// - Skid-buffer state encoding (value equals entries held).
package ex_mem_pkg;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_BRANCH   = 2;
  localparam int unsigned CTRL_ZERO     = 3;
  localparam int unsigned CTRL_MEMWRITE = 4;
  localparam int unsigned CTRL_MEMREAD  = 5;
  localparam int unsigned CTRL_ISGT     = 6;

  // Payload layout, LSB first: rd, funct, WriteData, ALU_result, PCplusimm.
  localparam int unsigned RD_OFF     = 0;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned FUNCT_OFF  = RD_OFF + RD_W;
  localparam int unsigned FUNCT_W    = 4;
  localparam int unsigned WDATA_OFF  = FUNCT_OFF + FUNCT_W;
  localparam int unsigned WDATA_W    = 64;
  localparam int unsigned ALU_OFF    = WDATA_OFF + WDATA_W;
  localparam int unsigned ALU_W      = 64;
  localparam int unsigned PCIMM_OFF  = ALU_OFF + ALU_W;
  localparam int unsigned PCIMM_W    = 64;
  localparam int unsigned PAYLOAD_W  = PCIMM_OFF + PCIMM_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/ex_mem_stage_reg_if.sv
// Valid/ready channel carrying a control bundle and a data payload.
// - master: drives valid, ctrl, data; receives ready.
// - slave:  receives valid, ctrl, data; drives ready.
interface ex_mem_stage_reg_if #(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned DATA_W = 201
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/ex_mem_stage_reg_slot.sv
// One storage entry of the stage: valid flag plus control and payload.
// Ports:
// - clk, reset     : clock, asynchronous active-high reset
// - load           : capture d_ctrl/d_data and mark valid
// - clear          : zero the entry (wins over load)
// - d_ctrl, d_data : data to capture
// - valid, ctrl, data : stored entry, all-zero when empty
module stage_slot #(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned DATA_W = 201
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Ports:
// - clk, reset : clock, asynchronous active-high reset
// - flush      : synchronous squash of every held entry
// - in_if      : slave channel from EX (valid/ready/ctrl/data)
// - out_if     : master channel to MEM; ctrl/data are zero whenever valid is low
// - occupancy  : entries held (0..2)
// - flush_cnt  : saturating count of flush cycles that discarded something
// Output is always the main entry. Empty entries are zeroed in storage so outputs stay
// flop-driven and a bubble never carries live control bits.
module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned DATA_W = 201,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  ex_mem_stage_reg_if.slave  in_if,
  ex_mem_stage_reg_if.master out_if,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  skid_state_e       state_q, state_d;
  logic              in_ready_q;
  logic              in_ready, xfer_in, xfer_out, flush_hit;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_d_data;
  logic [CNT_W-1:0]  flush_cnt_q;

  // With a skid entry, ready comes from a flop so out_ready never reaches in_ready.
  assign in_ready = (SKID != 0) ? in_ready_q : (!main_valid || out_if.ready);
  assign xfer_in  = in_if.valid && in_ready;
  assign xfer_out = main_valid && out_if.ready;
  assign flush_hit = flush && (main_valid || xfer_in);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else if (SKID != 0) begin
      case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            main_load = 1'b1;
            state_d   = HALF;
          end
        end
        HALF: begin
          if (xfer_in && xfer_out) begin
            main_load = 1'b1;
          end else if (xfer_in) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (xfer_out) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end else begin
      // Single entry: a same-cycle in & out simply replaces it.
      if (xfer_in) begin
        main_load = 1'b1;
        state_d   = HALF;
      end else if (xfer_out) begin
        main_clear = 1'b1;
        state_d    = EMPTY;
      end
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : in_if.ctrl;
  assign main_d_data = main_from_skid ? skid_data : in_if.data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      if (flush_hit && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  stage_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load),
    .clear  (main_clear),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .valid  (main_valid),
    .ctrl   (main_ctrl),
    .data   (main_data)
  );

  if (SKID != 0) begin : g_skid
    stage_slot #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .clear  (skid_clear),
      .d_ctrl (in_if.ctrl),
      .d_data (in_if.data),
      .valid  (skid_valid),
      .ctrl   (skid_ctrl),
      .data   (skid_data)
    );
  end else begin : g_no_skid
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = main_valid;
  assign out_if.ctrl  = main_ctrl;
  assign out_if.data  = main_data;
  // The skid entry is only ever valid alongside the main entry.
  assign occupancy    = {skid_valid, main_valid && !skid_valid};
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
module tb_ex_mem_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush1, flush0;
  logic [1:0]  occ1, occ0;
  logic [15:0] cnt1, cnt0;
  int          n_checks;
  int          n_fails;

  ex_mem_stage_reg_if #(.CTRL_W(7), .DATA_W(201)) in1 ();
  ex_mem_stage_reg_if #(.CTRL_W(7), .DATA_W(201)) out1 ();
  ex_mem_stage_reg_if #(.CTRL_W(7), .DATA_W(201)) in0 ();
  ex_mem_stage_reg_if #(.CTRL_W(7), .DATA_W(201)) out0 ();

  ex_mem_stage_reg #(.CTRL_W(7), .DATA_W(201), .SKID(1), .CNT_W(16)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush1),
    .in_if     (in1),
    .out_if    (out1),
    .occupancy (occ1),
    .flush_cnt (cnt1)
  );

  ex_mem_stage_reg #(.CTRL_W(7), .DATA_W(201), .SKID(0), .CNT_W(16)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush0),
    .in_if     (in0),
    .out_if    (out0),
    .occupancy (occ0),
    .flush_cnt (cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b1;
    flush1 = 1'b0; flush0 = 1'b0;
    in1.valid = 1'b0; in1.ctrl = '0; in1.data = '0; out1.ready = 1'b0;
    in0.valid = 1'b0; in0.ctrl = '0; in0.data = '0; out0.ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_valid", out1.valid, 0);
    chk("rst_ctrl", out1.ctrl, 0);
    chk("rst_data", out1.data, 0);
    chk("rst_occ", occ1, 0);
    chk("rst_cnt", cnt1, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in1.ready, 1);

    // Stream with out_ready=1: 1,2,3 appear one cycle later each
    out1.ready = 1'b1;
    in1.valid = 1'b1; in1.ctrl = 7'h01;
    for (int i = 1; i <= 3; i++) begin
      in1.data = 201'(i);
      tick();
      chk("stream_valid", out1.valid, 1);
      chk("stream_data", out1.data, i);
      chk("stream_occ", occ1, 1);
    end
    in1.valid = 1'b0;
    tick();
    chk("drain_valid", out1.valid, 0);
    chk("drain_data", out1.data, 0);
    chk("drain_occ", occ1, 0);

    // Stall: fill both entries
    out1.ready = 1'b0;
    in1.valid = 1'b1; in1.ctrl = 7'h11; in1.data = 201'hAA;
    tick();
    chk("stall_a_data", out1.data, 201'hAA);
    chk("stall_a_occ", occ1, 1);
    chk("stall_a_ready", in1.ready, 1);
    in1.ctrl = 7'h22; in1.data = 201'hBB;
    tick();
    chk("stall_full_occ", occ1, 2);
    chk("stall_full_ready", in1.ready, 0);
    chk("stall_hold_data", out1.data, 201'hAA);
    in1.ctrl = 7'h33; in1.data = 201'hCC;  // must be ignored while full
    tick();
    chk("stall_hold2_data", out1.data, 201'hAA);
    chk("stall_hold2_ctrl", out1.ctrl, 7'h11);
    chk("stall_hold2_occ", occ1, 2);
    in1.valid = 1'b0;
    out1.ready = 1'b1;
    tick();
    chk("release_b_data", out1.data, 201'hBB);
    chk("release_b_ctrl", out1.ctrl, 7'h22);
    chk("release_occ", occ1, 1);
    chk("release_ready", in1.ready, 1);
    tick();
    chk("release_empty_valid", out1.valid, 0);
    chk("release_empty_occ", occ1, 0);

    // Flush while FULL with in_valid asserted
    out1.ready = 1'b0;
    in1.valid = 1'b1; in1.ctrl = 7'h7F; in1.data = 201'h11;
    tick();
    in1.data = 201'h22;
    tick();
    chk("pre_flush_occ", occ1, 2);
    flush1 = 1'b1; in1.data = 201'h33;
    tick();
    flush1 = 1'b0; in1.valid = 1'b0;
    chk("flush_valid", out1.valid, 0);
    chk("flush_ctrl", out1.ctrl, 0);
    chk("flush_data", out1.data, 0);
    chk("flush_occ", occ1, 0);
    chk("flush_cnt", cnt1, 1);
    chk("flush_ready", in1.ready, 1);
    tick();
    chk("flush_no_leak", out1.valid, 0);

    // Flush when empty, no input: counter unchanged
    flush1 = 1'b1;
    tick();
    chk("flush_empty_cnt", cnt1, 1);

    // Flush while a transfer-in happens counts; drive to saturation
    in1.valid = 1'b1; in1.data = 201'h44;
    tick();
    chk("flush_xfer_cnt", cnt1, 2);
    chk("flush_xfer_valid", out1.valid, 0);
    repeat (65533) @(posedge clk);
    #1;
    chk("sat_reach", cnt1, 16'hFFFF);
    tick(); tick(); tick();
    chk("sat_hold", cnt1, 16'hFFFF);
    flush1 = 1'b0; in1.valid = 1'b0;

    // Reset mid-stream while HALF
    in1.valid = 1'b1; in1.ctrl = 7'h7F; in1.data = 201'h55;
    tick();
    chk("mid_pre_ctrl", out1.ctrl, 7'h7F);
    chk("mid_pre_occ", occ1, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", out1.valid, 0);
    chk("mid_rst_ctrl", out1.ctrl, 0);
    chk("mid_rst_data", out1.data, 0);
    chk("mid_rst_occ", occ1, 0);
    chk("mid_rst_cnt", cnt1, 0);
    in1.valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", in1.ready, 1);
    tick();
    chk("mid_rst_still_empty", out1.valid, 0);

    // SKID=0: combinational in_ready and single-cycle replace
    in0.valid = 1'b1; in0.ctrl = 7'h05; in0.data = 201'h10;
    out0.ready = 1'b0;
    tick();
    chk("s0_first_data", out0.data, 201'h10);
    chk("s0_first_occ", occ0, 1);
    in0.data = 201'h20;
    #1;
    chk("s0_stall_ready", in0.ready, 0);
    tick();
    chk("s0_hold_data", out0.data, 201'h10);
    out0.ready = 1'b1;
    #1;
    chk("s0_release_ready", in0.ready, 1);
    tick();
    chk("s0_replace_data", out0.data, 201'h20);
    chk("s0_replace_occ", occ0, 1);
    in0.data = 201'h30;
    tick();
    chk("s0_next_data", out0.data, 201'h30);
    in0.valid = 1'b0;
    tick();
    chk("s0_empty_valid", out0.valid, 0);
    chk("s0_empty_data", out0.data, 0);

    // SKID=0 flush of a held entry
    out0.ready = 1'b0;
    in0.valid = 1'b1; in0.data = 201'h40;
    tick();
    in0.valid = 1'b0;
    flush0 = 1'b1;
    tick();
    flush0 = 1'b0;
    chk("s0_flush_valid", out0.valid, 0);
    chk("s0_flush_cnt", cnt0, 1);
    chk("s0_flush_occ", occ0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
